// File: rtl/risc_mips_pkg.sv
// Shared MIPS32 definitions: opcodes, fetch state encoding, word width.
// Used by the prefetch queue (optional PFQ_BYPASS_EN build) and its FIFO.
package risc_mips_pkg;

   localparam int IR_W = 32;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_AND   = 6'b000010;
   localparam logic [5:0] OP_OR    = 6'b000011;
   localparam logic [5:0] OP_SLT   = 6'b000100;
   localparam logic [5:0] OP_MUL   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b001000;
   localparam logic [5:0] OP_SW    = 6'b001001;
   localparam logic [5:0] OP_ADDI  = 6'b001010;
   localparam logic [5:0] OP_SUBI  = 6'b001011;
   localparam logic [5:0] OP_SLTI  = 6'b001100;
   localparam logic [5:0] OP_BNEQZ = 6'b001101;
   localparam logic [5:0] OP_BEQZ  = 6'b001110;
   localparam logic [5:0] OP_HLT   = 6'b111111;

   typedef enum logic [1:0] {
      ST_REQ,
      ST_WAIT,
      ST_DISCARD,
      ST_HALT
   } fetch_state_e;

   function automatic logic is_hlt(input logic [5:0] op);
      return op == OP_HLT;
   endfunction

endpackage

// File: rtl/pfq_fifo.sv
// Prefetch FIFO of {ir, npc} with a registered head that holds its
// last value while the queue is empty.
module pfq_fifo
   import risc_mips_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int NPC_W = 10,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             CLK1,
   input  logic             RST,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [IR_W-1:0]  wr_ir,
   input  logic [NPC_W-1:0] wr_npc,
   output logic [CNT_W-1:0] count,
   output logic [IR_W-1:0]  head_ir,
   output logic [NPC_W-1:0] head_npc
);

   logic [IR_W-1:0]  mem_ir  [DEPTH];
   logic [NPC_W-1:0] mem_npc [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_nxt;

   assign rd_nxt = rd_ptr + 1'b1;

   always_ff @(posedge CLK1) begin
      if (push && !flush) begin
         mem_ir[wr_ptr]  <= wr_ir;
         mem_npc[wr_ptr] <= wr_npc;
      end
   end

   // head tracks mem[rd_ptr] whenever the queue holds an entry
   always_ff @(posedge CLK1) begin
      if (RST) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         head_ir  <= '0;
         head_npc <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_nxt;
         count <= count + CNT_W'(push) - CNT_W'(pop);
         if (pop && count > CNT_W'(1)) begin
            head_ir  <= mem_ir[rd_nxt];
            head_npc <= mem_npc[rd_nxt];
         end else if (push && (count == '0 || pop)) begin
            head_ir  <= wr_ir;
            head_npc <= wr_npc;
         end
      end
   end

endmodule

// File: rtl/ifetch_prefetch_queue.sv
// Instruction prefetch queue: one outstanding imem read, FIFO to IF/ID.
// Define PFQ_BYPASS_EN to forward a response straight to an empty head.
module ifetch_prefetch_queue
   import risc_mips_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                     CLK1,
   input  logic                     RST,
   input  logic                     redirect_valid,
   input  logic [ADDR_W-1:0]        redirect_pc,
   output logic                     imem_req,
   output logic [ADDR_W-1:0]        imem_addr,
   input  logic                     imem_gnt,
   input  logic                     imem_rvalid,
   input  logic [31:0]              imem_rdata,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_ir,
   output logic [ADDR_W-1:0]        out_npc,
   output logic [$clog2(DEPTH):0]   q_count,
   output logic                     halted
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   fetch_state_e      state;
   fetch_state_e      state_nxt;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] pend_pc;
   logic [ADDR_W-1:0] rsp_npc;
   logic [IR_W-1:0]   head_ir;
   logic [ADDR_W-1:0] head_npc;
   logic              grant;
   logic              rsp_live;
   logic              rsp_hlt;
   logic              q_empty;
   logic              byp;
   logic              push;
   logic              pop;

   assign q_empty  = q_count == '0;
   assign rsp_live = (state == ST_WAIT) && imem_rvalid;
   assign rsp_hlt  = is_hlt(imem_rdata[31:26]);
   assign rsp_npc  = pend_pc + 1'b1;

   assign imem_req = (state == ST_REQ) && (q_count < CNT_W'(DEPTH))
                     && !redirect_valid && !RST;
   assign imem_addr = fetch_pc;
   assign grant     = imem_req && imem_gnt;

`ifdef PFQ_BYPASS_EN
   assign byp = q_empty && rsp_live;
`else
   assign byp = 1'b0;
`endif

   assign out_valid = (!q_empty || byp) && !redirect_valid && !RST;
   assign out_ir    = byp ? imem_rdata : head_ir;
   assign out_npc   = byp ? rsp_npc : head_npc;

   assign pop  = out_valid && out_ready && !q_empty;
   assign push = rsp_live && !redirect_valid && !(byp && out_ready);

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_REQ:     if (grant) state_nxt = ST_WAIT;
         ST_WAIT:    if (imem_rvalid) state_nxt = rsp_hlt ? ST_HALT : ST_REQ;
         ST_DISCARD: if (imem_rvalid) state_nxt = ST_REQ;
         ST_HALT:    state_nxt = ST_HALT;
         default:    state_nxt = ST_REQ;
      endcase
      // a read still in flight must be absorbed before refetching
      if (redirect_valid)
         state_nxt = ((state == ST_WAIT || state == ST_DISCARD) && !imem_rvalid)
                     ? ST_DISCARD : ST_REQ;
   end

   always_ff @(posedge CLK1) begin
      if (RST) begin
         state    <= ST_REQ;
         fetch_pc <= RESET_PC;
         pend_pc  <= '0;
         halted   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            halted   <= 1'b0;
         end else begin
            if (grant) begin
               pend_pc  <= fetch_pc;
               fetch_pc <= fetch_pc + 1'b1;
            end
            if (rsp_live && rsp_hlt) halted <= 1'b1;
         end
      end
   end

   pfq_fifo #(
      .DEPTH (DEPTH),
      .NPC_W (ADDR_W)
   ) u_fifo (
      .CLK1     (CLK1),
      .RST      (RST),
      .push     (push),
      .pop      (pop),
      .flush    (redirect_valid),
      .wr_ir    (imem_rdata),
      .wr_npc   (rsp_npc),
      .count    (q_count),
      .head_ir  (head_ir),
      .head_npc (head_npc)
   );

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Bench for ifetch_prefetch_queue: memory emulator, queue-based model,
// directed scenarios with literal pins, then randomized traffic.
module tb_ifetch_prefetch_queue;

   localparam int AW = 10;
   localparam int DEPTH = 4;

   logic          CLK1 = 1'b0;
   logic          RST;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_gnt;
   logic          imem_rvalid;
   logic [31:0]   imem_rdata;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_ir;
   logic [AW-1:0] out_npc;
   logic [2:0]    q_count;
   logic          halted;

   always #5 CLK1 = ~CLK1;

   ifetch_prefetch_queue #(.ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC('0)) dut (
      .CLK1(CLK1), .RST(RST),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_ir(out_ir), .out_npc(out_npc),
      .q_count(q_count), .halted(halted)
   );

   typedef struct packed {
      logic [31:0]   ir;
      logic [AW-1:0] npc;
   } ent_t;

   logic [31:0] MEM [1024];
   ent_t mq[$];
   ent_t cons[$];
   int   gaddr[$];

   logic [AW-1:0] m_pc, m_pend, m_last_npc;
   logic [31:0]   m_last_ir;
   int            m_outst;
   bit            m_halt;
   bit            c_req, c_valid, c_byp;
   logic          s_req;
   logic [AW-1:0] s_addr;

   bit          mem_pend;
   int          mem_wait;
   logic [31:0] mem_data;
   int          lat_hi;

   int n_chk = 0;
   int n_fail = 0;

   task automatic cmp(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rand_word(input bit allow_hlt);
      logic [31:0] w;
      w = $urandom;
      if (w[31:26] == 6'h3f) w[31] = 1'b0;
      if (allow_hlt && $urandom_range(99, 0) < 3) w[31:26] = 6'h3f;
      return w;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_pc = '0; m_pend = '0; m_outst = 0; m_halt = 0;
      m_last_ir = '0; m_last_npc = '0;
      mem_pend = 0; mem_wait = 0;
   endtask

   task automatic check();
      logic [31:0]   eir;
      logic [AW-1:0] enpc;
      c_req = !m_halt && m_outst == 0 && mq.size() < DEPTH && !redirect_valid;
      c_byp = 0;
`ifdef PFQ_BYPASS_EN
      c_byp = mq.size() == 0 && m_outst == 1 && imem_rvalid;
`endif
      c_valid = (mq.size() != 0 || c_byp) && !redirect_valid;
      if (c_byp) begin
         eir = imem_rdata; enpc = m_pend + 1'b1;
      end else if (mq.size() != 0) begin
         eir = mq[0].ir; enpc = mq[0].npc;
      end else begin
         eir = m_last_ir; enpc = m_last_npc;
      end
      cmp("imem_req", imem_req, c_req);
      cmp("imem_addr", imem_addr, m_pc);
      cmp("out_valid", out_valid, c_valid);
      cmp("out_ir", out_ir, eir);
      cmp("out_npc", out_npc, enpc);
      cmp("q_count", q_count, mq.size());
      cmp("halted", halted, m_halt);
      s_req = imem_req;
      s_addr = imem_addr;
      if (out_valid && out_ready) cons.push_back({out_ir, out_npc});
   endtask

   task automatic model_update();
      logic [AW-1:0] np;
      np = m_pend + 1'b1;
      if (redirect_valid) begin
         mq.delete();
         m_pc = redirect_pc;
         m_halt = 0;
         m_outst = (m_outst != 0 && !imem_rvalid) ? 2 : 0;
      end else begin
         if (c_valid && out_ready && mq.size() != 0) void'(mq.pop_front());
         if (m_outst == 1 && imem_rvalid) begin
            if (!(c_byp && out_ready)) mq.push_back({imem_rdata, np});
            if (imem_rdata[31:26] == 6'h3f) m_halt = 1;
            m_outst = 0;
         end else if (m_outst == 2 && imem_rvalid) begin
            m_outst = 0;
         end
         if (c_req && imem_gnt) begin
            m_pend = m_pc;
            m_pc = m_pc + 1'b1;
            m_outst = 1;
         end
      end
      if (mq.size() != 0) begin
         m_last_ir = mq[0].ir;
         m_last_npc = mq[0].npc;
      end
   endtask

   task automatic step(input bit rdv, input logic [AW-1:0] rpc,
                       input bit rdy, input bit g);
      @(negedge CLK1);
      redirect_valid = rdv;
      redirect_pc = rpc;
      out_ready = rdy;
      imem_gnt = g;
      if (mem_pend && mem_wait == 0) begin
         imem_rvalid = 1'b1;
         imem_rdata = mem_data;
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata = $urandom;
         if (mem_pend) mem_wait--;
      end
      #1;
      if (!RST) check();
      @(posedge CLK1);
      if (RST) begin
         model_reset();
      end else begin
         model_update();
         if (imem_rvalid) mem_pend = 0;
         if (s_req && imem_gnt) begin
            mem_pend = 1;
            mem_wait = $urandom_range(lat_hi - 1, 0);
            mem_data = MEM[s_addr];
            gaddr.push_back(int'(s_addr));
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int g0, c0, k;
      bit found;
      for (int i = 0; i < 1024; i++) MEM[i] = rand_word(0);
      MEM[0] = 32'h28010005; MEM[1] = 32'h28020006;
      MEM[2] = 32'h28030007; MEM[3] = 32'h28040008;
      MEM[4] = 32'h28050009; MEM[5] = 32'hFC000000;
      lat_hi = 1;
      RST = 1'b1;
      redirect_valid = 0; redirect_pc = '0; out_ready = 0;
      imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
      repeat (3) step(0, '0, 0, 0);
      #2;
      cmp("rst_q_count", q_count, 0);
      cmp("rst_out_ir", out_ir, 0);
      cmp("rst_out_npc", out_npc, 0);
      cmp("rst_halted", halted, 0);
      cmp("rst_imem_req", imem_req, 0);
      cmp("rst_imem_addr", imem_addr, 0);
      cmp("rst_out_valid", out_valid, 0);
      RST = 1'b0;

      // straight-line fetch into HLT at word 5
      repeat (30) step(0, '0, 1, 1);
      #2;
      cmp("halt_grants", gaddr.size(), 6);
      cmp("grant0", gaddr[0], 0);
      cmp("grant1", gaddr[1], 1);
      cmp("grant2", gaddr[2], 2);
      cmp("cons_n", cons.size(), 6);
      cmp("cons0_ir", cons[0].ir, 32'h28010005);
      cmp("cons0_npc", cons[0].npc, 1);
      cmp("cons1_ir", cons[1].ir, 32'h28020006);
      cmp("cons1_npc", cons[1].npc, 2);
      cmp("cons2_ir", cons[2].ir, 32'h28030007);
      cmp("cons2_npc", cons[2].npc, 3);
      cmp("cons5_npc", cons[5].npc, 6);
      cmp("halted_set", halted, 1);
      cmp("halt_no_req", imem_req, 0);

      // redirect out of halt, then let the queue saturate
      g0 = gaddr.size(); c0 = cons.size();
      step(1, 10'h040, 0, 1);
      #2;
      cmp("halt_clear", halted, 0);
      cmp("redir_q0", q_count, 0);
      repeat (12) step(0, '0, 0, 1);
      #2;
      cmp("sat_q_count", q_count, 4);
      cmp("sat_no_req", imem_req, 0);
      cmp("sat_grants", gaddr.size() - g0, 4);
      cmp("sat_addr0", gaddr[g0], 32'h40);
      repeat (12) step(0, '0, 1, 1);
      for (int i = 0; i < 4; i++) begin
         cmp("drain_npc", cons[c0 + i].npc, 32'h41 + i);
         cmp("drain_ir", cons[c0 + i].ir, MEM[32'h40 + i]);
      end
      cmp("resume_addr", gaddr[g0 + 4], 32'h44);

      // redirect while a 3-cycle read is outstanding
      step(1, 10'h100, 1, 1);
      lat_hi = 3;
      g0 = gaddr.size(); k = 0;
      while (gaddr.size() == g0 && k < 10) begin
         step(0, '0, 1, 1);
         k++;
      end
      cmp("grant_seen", gaddr.size() > g0, 1);
      lat_hi = 1;
      g0 = gaddr.size(); c0 = cons.size();
      step(1, 10'h200, 1, 1);
      #2;
      cmp("wait_redir_q0", q_count, 0);
      repeat (15) step(0, '0, 1, 1);
      cmp("stale_dropped_ir", cons[c0].ir, MEM[10'h200]);
      cmp("stale_dropped_npc", cons[c0].npc, 32'h201);
      cmp("refetch_addr", gaddr[g0], 32'h200);

      // redirect on the same cycle as a live response
      found = 0; k = 0;
      while (!found && k < 10) begin
         if (mem_pend && mem_wait == 0) found = 1;
         else begin
            step(0, '0, 1, 1);
            k++;
         end
      end
      cmp("rsp_seen", found, 1);
      g0 = gaddr.size(); c0 = cons.size();
      step(1, 10'h300, 1, 1);
      #2;
      cmp("coin_q0", q_count, 0);
      cmp("coin_no_pop", cons.size(), c0);
      repeat (8) step(0, '0, 1, 1);
      cmp("coin_addr", gaddr[g0], 32'h300);
      cmp("coin_npc", cons[c0].npc, 32'h301);

      // address wrap at the top of memory
      g0 = gaddr.size(); c0 = cons.size();
      step(1, 10'h3ff, 1, 1);
      repeat (8) step(0, '0, 1, 1);
      cmp("wrap_addr0", gaddr[g0], 32'h3ff);
      cmp("wrap_addr1", gaddr[g0 + 1], 0);
      cmp("wrap_ir", cons[c0].ir, MEM[1023]);
      cmp("wrap_npc", cons[c0].npc, 0);

      // randomized traffic
      for (int i = 0; i < 1024; i++) MEM[i] = rand_word(1);
      lat_hi = 3;
      for (int i = 0; i < 3000; i++) begin
         logic [AW-1:0] rp;
         rp = AW'($urandom);
         if ($urandom_range(7, 0) == 0) rp = AW'(1020 + $urandom_range(3, 0));
         step($urandom_range(99, 0) < 4, rp,
              $urandom_range(9, 0) < 7, $urandom_range(3, 0) != 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
